// File: rtl/wdt_pkg.sv
// ---------------------------------------------------------------------------
// wdt_pkg
// Shared types for the watchdog reset controller.
//   rst_cause_e : encoding of the last recorded reset cause (cause_o)
//   rst_fsm_e   : reset pulse sequencer states
// ---------------------------------------------------------------------------
package wdt_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_WDT  = 2'b01,
      CAUSE_SW   = 2'b10
   } rst_cause_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ASSERT  = 2'b01,
      HOLDOFF = 2'b10
   } rst_fsm_e;

endpackage

// File: rtl/wdt_edge_det.sv
// ---------------------------------------------------------------------------
// wdt_edge_det
// Rising-edge detector for one level input, with an optional 2-flop
// synchronizer in front (enabled by defining WDT_RST_SYNC_EN).
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   sig_i   : raw level input
//   level_o : level as seen by the detector (synchronized when enabled)
//   rise_o  : combinational 1-cycle pulse when level_o goes 0 -> 1
// ---------------------------------------------------------------------------
module wdt_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o
);

`ifdef WDT_RST_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], sig_i};
   end

   assign level_o = sync_q[1];
`else
   assign level_o = sig_i;
`endif

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level_o;
   end

   assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/wdt_reset_ctrl.sv
// ---------------------------------------------------------------------------
// wdt_reset_ctrl
// Turns watchdog timeout / software reset request edges into a fixed-width
// stretched system reset, keeps a sticky warning interrupt, and records the
// last reset cause plus a saturating reset-event counter.
// Optional build macro: WDT_RST_SYNC_EN (2-flop input synchronizers,
// event-to-sys_rst_o latency 3 cycles instead of 1).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   wdt_reset_i     : watchdog timeout level (rising edge = event)
//   wdt_warning_i   : watchdog warning level (rising edge = event)
//   sw_rst_req_i    : software reset request level (rising edge = event)
//   irq_ack_i       : clears warn_irq_o
//   clr_cause_i     : clears cause_o and reset_count_o
//   sys_rst_o       : stretched reset, PULSE_CYCLES cycles per event
//   warn_irq_o      : sticky warning interrupt
//   cause_o         : last cause (00 none, 01 watchdog, 10 software)
//   reset_count_o   : saturating count of reset pulses
//   busy_o          : high while in ASSERT or HOLDOFF
// ---------------------------------------------------------------------------
module wdt_reset_ctrl
   import wdt_pkg::*;
#(
   parameter int PULSE_CYCLES = 16,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wdt_reset_i,
   input  logic             wdt_warning_i,
   input  logic             sw_rst_req_i,
   input  logic             irq_ack_i,
   input  logic             clr_cause_i,
   output logic             sys_rst_o,
   output logic             warn_irq_o,
   output logic [1:0]       cause_o,
   output logic [CNT_W-1:0] reset_count_o,
   output logic             busy_o
);

   localparam int PCW = $clog2(PULSE_CYCLES + 1);
   localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES);

   logic wdt_lvl, wdt_rise;
   logic sw_lvl, sw_rise;
   logic warn_lvl_unused, warn_rise;

   wdt_edge_det u_det_wdt (
      .clk(clk), .rst(rst), .sig_i(wdt_reset_i),
      .level_o(wdt_lvl), .rise_o(wdt_rise)
   );

   wdt_edge_det u_det_sw (
      .clk(clk), .rst(rst), .sig_i(sw_rst_req_i),
      .level_o(sw_lvl), .rise_o(sw_rise)
   );

   wdt_edge_det u_det_warn (
      .clk(clk), .rst(rst), .sig_i(wdt_warning_i),
      .level_o(warn_lvl_unused), .rise_o(warn_rise)
   );

   rst_fsm_e         state_q, state_d;
   logic [PCW-1:0]   pcnt_q, pcnt_d;
   logic             sys_rst_q, sys_rst_d;
   logic             warn_q, warn_d;
   rst_cause_e       cause_q, cause_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pcnt_q    <= '0;
         sys_rst_q <= 1'b0;
         warn_q    <= 1'b0;
         cause_q   <= CAUSE_NONE;
         count_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         sys_rst_q <= sys_rst_d;
         warn_q    <= warn_d;
         cause_q   <= cause_d;
         count_q   <= count_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      sys_rst_d = 1'b0;
      warn_d    = warn_q;
      cause_d   = cause_q;
      count_d   = count_q;

      // Lowest priority first: clears are overridden below by a new event.
      if (clr_cause_i) begin
         cause_d = CAUSE_NONE;
         count_d = '0;
      end
      if (irq_ack_i) warn_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (wdt_rise || sw_rise) begin
               state_d   = ASSERT;
               sys_rst_d = 1'b1;
               // pcnt counts cycles sys_rst_o has already been high
               pcnt_d    = PCW'(1);
               cause_d   = wdt_rise ? CAUSE_WDT : CAUSE_SW;
               if (clr_cause_i)       count_d = CNT_W'(1);
               else if (&count_q)     count_d = count_q;
               else                   count_d = count_q + CNT_W'(1);
               warn_d    = 1'b0;
            end else if (warn_rise) begin
               warn_d = 1'b1;
            end
         end
         ASSERT: begin
            if (pcnt_q == PULSE_LAST) begin
               state_d = HOLDOFF;
            end else begin
               pcnt_d    = pcnt_q + PCW'(1);
               sys_rst_d = 1'b1;
            end
         end
         HOLDOFF: begin
            if (!wdt_lvl && !sw_lvl) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sys_rst_o     = sys_rst_q;
   assign warn_irq_o    = warn_q;
   assign cause_o       = cause_q;
   assign reset_count_o = count_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
module tb_wdt_reset_ctrl;

`ifdef WDT_RST_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int PULSE = 16;

   logic clk, rst;
   logic wdt, warn, sw, ack, clr;
   logic sys_rst, warn_irq, busy;
   logic [1:0] cause;
   logic [7:0] count;
   logic s2_sys_rst, s2_warn_irq, s2_busy;
   logic [1:0] s2_cause;
   logic [1:0] s2_count;

   int n_tests = 0;
   int n_fail  = 0;

   wdt_reset_ctrl #(.PULSE_CYCLES(PULSE), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .wdt_reset_i(wdt), .wdt_warning_i(warn),
      .sw_rst_req_i(sw), .irq_ack_i(ack), .clr_cause_i(clr),
      .sys_rst_o(sys_rst), .warn_irq_o(warn_irq), .cause_o(cause),
      .reset_count_o(count), .busy_o(busy)
   );

   // Narrow-counter instance sharing all stimulus, for saturation checks.
   wdt_reset_ctrl #(.PULSE_CYCLES(PULSE), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .wdt_reset_i(wdt), .wdt_warning_i(warn),
      .sw_rst_req_i(sw), .irq_ack_i(ack), .clr_cause_i(clr),
      .sys_rst_o(s2_sys_rst), .warn_irq_o(s2_warn_irq), .cause_o(s2_cause),
      .reset_count_o(s2_count), .busy_o(s2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits until sys_rst reaches val; returns cycles waited. Timeout counts as a failure.
   task automatic wait_rst(input logic val, output int cyc);
      cyc = 0;
      while (sys_rst !== val && cyc < 60) begin
         tick(1);
         cyc++;
      end
      if (sys_rst !== val) begin
         n_tests++; n_fail++;
         $display("FAIL wait_sys_rst: timeout, sys_rst=%b required %b", sys_rst, val);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; wdt = 0; warn = 0; sw = 0; ack = 0; clr = 0;
      tick(3);
      rst = 1'b0;
      tick(1);
      n_tests++; if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst: got %b need 0", sys_rst); end
      n_tests++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL reset_warn: got %b need 0", warn_irq); end
      n_tests++; if (cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b need 00", cause); end
      n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d need 0", count); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_wdt_pulse;
      int lat, width;
      wdt = 1'b1;
      lat = 0;
      while (sys_rst !== 1'b1 && lat < 10) begin tick(1); lat++; end
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL wdt_latency: got %0d need %0d", lat, LAT); end
      n_tests++; if (cause !== 2'b01) begin n_fail++; $display("FAIL wdt_cause: got %b need 01", cause); end
      n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL wdt_count: got %0d need 1", count); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wdt_busy_assert: got %b need 1", busy); end
      width = 0;
      while (sys_rst === 1'b1 && width < 40) begin width++; tick(1); end
      n_tests++; if (width !== PULSE) begin n_fail++; $display("FAIL wdt_width: got %0d need %0d", width, PULSE); end
      tick(3);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wdt_holdoff_busy: got %b need 1", busy); end
      wdt = 1'b0;
      tick(LAT);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wdt_release_busy: got %b need 0", busy); end
      $display("[TB] test_wdt_pulse done lat=%0d width=%0d", lat, width);
   endtask

   task automatic test_both_same_cycle;
      int cyc;
      clr = 1'b1; tick(1); clr = 1'b0;
      n_tests++; if (cause !== 2'b00 || count !== 8'd0) begin n_fail++; $display("FAIL clr_alone: got cause=%b count=%0d need 00/0", cause, count); end
      wdt = 1'b1; sw = 1'b1;
      wait_rst(1'b1, cyc);
      n_tests++; if (cause !== 2'b01) begin n_fail++; $display("FAIL both_cause: got %b need 01", cause); end
      n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL both_count: got %0d need 1", count); end
      sw = 1'b0; tick(3); sw = 1'b1; tick(3);
      wait_rst(1'b0, cyc);
      wdt = 1'b0; sw = 1'b0;
      tick(LAT + 6);
      n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL sw_during_assert_count: got %0d need 1", count); end
      n_tests++; if (sys_rst !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sw_during_assert_idle: got rst=%b busy=%b need 0/0", sys_rst, busy); end
      $display("[TB] test_both_same_cycle done");
   endtask

   task automatic test_warning;
      int cyc;
      warn = 1'b1; tick(LAT);
      n_tests++; if (warn_irq !== 1'b1) begin n_fail++; $display("FAIL warn_set: got %b need 1", warn_irq); end
      warn = 1'b0; tick(4);
      warn = 1'b1; tick(LAT - 1);
      ack = 1'b1; tick(1); ack = 1'b0;
      n_tests++; if (warn_irq !== 1'b1) begin n_fail++; $display("FAIL warn_set_beats_ack: got %b need 1", warn_irq); end
      ack = 1'b1; tick(1); ack = 1'b0;
      n_tests++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL warn_ack: got %b need 0", warn_irq); end
      warn = 1'b0; tick(4);
      warn = 1'b1; tick(LAT);
      n_tests++; if (warn_irq !== 1'b1) begin n_fail++; $display("FAIL warn_reset_again: got %b need 1", warn_irq); end
      warn = 1'b0;
      wdt = 1'b1;
      wait_rst(1'b1, cyc);
      n_tests++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL warn_cleared_by_rst: got %b need 0", warn_irq); end
      wait_rst(1'b0, cyc);
      wdt = 1'b0; tick(LAT + 4);
      $display("[TB] test_warning done");
   endtask

   task automatic test_count_sat;
      int cyc;
      logic [1:0] exp2;
      clr = 1'b1; tick(1); clr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         sw = 1'b1;
         wait_rst(1'b1, cyc);
         exp2 = (i > 3) ? 2'd3 : 2'(i);
         n_tests++; if (s2_count !== exp2) begin n_fail++; $display("FAIL sat_count_%0d: got %0d need %0d", i, s2_count, exp2); end
         n_tests++; if (count !== 8'(i)) begin n_fail++; $display("FAIL wide_count_%0d: got %0d need %0d", i, count, i); end
         n_tests++; if (s2_cause !== 2'b10) begin n_fail++; $display("FAIL sat_cause_%0d: got %b need 10", i, s2_cause); end
         wait_rst(1'b0, cyc);
         sw = 1'b0; tick(LAT + 3);
      end
      sw = 1'b1; tick(LAT - 1);
      clr = 1'b1; tick(1); clr = 1'b0;
      n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL clr_event_rst: got %b need 1", sys_rst); end
      n_tests++; if (s2_count !== 2'd1 || count !== 8'd1) begin n_fail++; $display("FAIL clr_event_count: got %0d/%0d need 1/1", s2_count, count); end
      n_tests++; if (cause !== 2'b10) begin n_fail++; $display("FAIL clr_event_cause: got %b need 10", cause); end
      wait_rst(1'b0, cyc);
      sw = 1'b0; tick(LAT + 3);
      $display("[TB] test_count_sat done");
   endtask

   task automatic test_async_reset;
      int cyc, lat;
      wdt = 1'b1;
      wait_rst(1'b1, cyc);
      tick(4);
      #2 rst = 1'b1;
      #1;
      n_tests++; if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL async_rst_sys_rst: got %b need 0", sys_rst); end
      n_tests++; if (busy !== 1'b0 || cause !== 2'b00) begin n_fail++; $display("FAIL async_rst_state: got busy=%b cause=%b need 0/00", busy, cause); end
      wdt = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);
      n_tests++; if (busy !== 1'b0 || sys_rst !== 1'b0) begin n_fail++; $display("FAIL async_post_idle: got busy=%b rst=%b need 0/0", busy, sys_rst); end
      wdt = 1'b1;
      lat = 0;
      while (sys_rst !== 1'b1 && lat < 10) begin tick(1); lat++; end
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL async_post_latency: got %0d need %0d", lat, LAT); end
      wait_rst(1'b0, cyc);
      wdt = 1'b0; tick(LAT + 2);
      $display("[TB] test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_wdt_pulse();
      test_both_same_cycle();
      test_warning();
      test_count_sat();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wdt_reset_ctrl.md
Name: wdt_reset_ctrl

Overview:
Sits directly downstream of the watchdog timer and consumes its wdt_reset / wdt_warning outputs plus a software reset request. It produces a fixed-width stretched system reset pulse and a sticky warning interrupt with acknowledge. It also records the last reset cause and a saturating reset-event count, so firmware can inspect them after reboot.

Parameters:
PULSE_CYCLES, 16, number of cycles sys_rst_o stays high per event (legal range >= 1)
CNT_W, 8, width of the saturating reset-event counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wdt_reset_i  input  1  level from watchdog; rising edge = timeout event
wdt_warning_i  input  1  level from watchdog; rising edge = warning event
sw_rst_req_i  input  1  software reset request level; rising edge = event
irq_ack_i  input  1  single-cycle pulse; clears warn_irq_o
clr_cause_i  input  1  single-cycle pulse; clears cause_o and reset_count_o
sys_rst_o  output  1  stretched system reset, active-high
warn_irq_o  output  1  sticky warning interrupt
cause_o  output  2  last cause: 00 none, 01 watchdog, 10 software
reset_count_o  output  CNT_W  saturating count of sys_rst_o pulses
busy_o  output  1  high in ASSERT or HOLDOFF

Behaviour:
- Interface: one clock clk; reset rst, asynchronous, active-high.
- Reset values: all outputs 0. Edge-detect registers are 0. FSM is in IDLE. Reset mid-pulse aborts the pulse immediately.
- Edge detect: each input is compared with its registered previous value. A rising edge is cur=1 and prev=0.
- FSM states: IDLE, ASSERT, HOLDOFF.
- IDLE: a wdt or sw rising edge moves the FSM to ASSERT. sys_rst_o is 1 from the clock edge that samples the edge (registered output, 1-cycle latency).
- ASSERT: sys_rst_o=1 for exactly PULSE_CYCLES cycles, then the FSM goes to HOLDOFF with sys_rst_o=0. The pulse counter width is $clog2(PULSE_CYCLES+1).
- HOLDOFF: the FSM returns to IDLE on the first sampled cycle with wdt_reset_i=0 and sw_rst_req_i=0.
- Edges arriving in ASSERT/HOLDOFF are ignored. They do not queue, and they do not change the cause or count.
- Entering ASSERT:
  - cause_o is set to 01 (wdt) or 10 (sw). If both edges occur in the same cycle, wdt wins.
  - reset_count_o increments and saturates at all-ones.
  - warn_irq_o is cleared.
- Warning:
  - A wdt_warning_i rising edge in IDLE sets warn_irq_o.
  - irq_ack_i clears it.
  - Set and ack in the same cycle: set wins.
  - Warning edges in ASSERT/HOLDOFF are ignored.
- clr_cause_i:
  - Alone, it clears cause_o to 00 and reset_count_o to 0.
  - In the same cycle as ASSERT entry, the new event wins: cause is the new cause and count=1.
  - It has no effect on sys_rst_o or the FSM.
- busy_o equals (state != IDLE), registered along with the state.

Optional Feature:
WDT_RST_SYNC_EN
- Defined: wdt_reset_i, wdt_warning_i and sw_rst_req_i each pass through a 2-flop synchronizer (reset to 0) before edge detection. Event-to-sys_rst_o latency becomes 3 cycles.
- Undefined: inputs are used directly, with 1-cycle latency.
- All other behaviour is identical in both builds.

Decomposition:
- Package wdt_pkg holds:
  - typedef enum logic [1:0] rst_cause_e {CAUSE_NONE, CAUSE_WDT, CAUSE_SW}
  - typedef enum rst_fsm_e {IDLE, ASSERT, HOLDOFF}
- One sub-module: wdt_edge_det. It holds the optional 2-flop sync and a rising-edge pulse output, and is instantiated three times.

Test Plan:
- rst high for 3 cycles, then released -> all outputs 0, busy_o=0.
- wdt_reset_i 0->1 at cycle 10, PULSE_CYCLES=16 -> sys_rst_o high cycles 11..26, cause_o=01, reset_count_o=1. The FSM stays in HOLDOFF until wdt_reset_i drops, then busy_o=0.
- wdt_reset_i and sw_rst_req_i rise in the same cycle -> one pulse, cause_o=01, count=1. A sw edge issued during ASSERT is ignored (count stays 1).
- wdt_warning_i rise -> warn_irq_o=1. irq_ack_i coincident with a second warning edge -> warn_irq_o stays 1. A lone ack -> 0. A subsequent wdt_reset edge also clears warn_irq_o.
- CNT_W=2, 5 sw events -> reset_count_o 1,2,3,3,3. clr_cause_i coincident with a 6th event -> count=1, cause_o=10.
- rst asserted at cycle 5 of a pulse -> sys_rst_o=0 immediately (asynchronous). After release the FSM is in IDLE. With WDT_RST_SYNC_EN, the 0->1 to sys_rst_o latency is 3 cycles.
